// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// spi_reg_bank : control/status register map behind the SPI slave (VNA DSP)
// Revision     : 1.0
// ============================================================================
module spi_reg_bank #(
   parameter int                    ADDR_WIDTH = 7,
   parameter int                    DATA_WIDTH = 24,
   parameter int                    NUM_CFG    = 12,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 24'h564E41
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         addr,
   input  logic                          addr_ready,
   input  logic                          rw,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          wr_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   input  logic [7:0]                    status_set,
   output logic                          ctrl_enable,
   output logic                          start_pulse,
   output logic                          wr_strobe,
   output logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_flat,
   output logic [7:0]                    bad_addr_count
);

   localparam logic [ADDR_WIDTH-1:0] C_A_ID      = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] C_A_CTRL    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] C_A_STATUS  = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] C_A_SCRATCH = ADDR_WIDTH'(3);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                          state_q, state_d;
   logic                            ar_q, wv_q, arm_q, arm_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic                            rw_q, rw_d;
   logic [DATA_WIDTH-1:0]           rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0]           ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0]           scratch_q, scratch_d;
   logic [7:0]                      sticky_q, sticky_d;
   logic [7:0]                      bad_cnt_q, bad_cnt_d;
   logic [NUM_CFG*DATA_WIDTH-1:0]   cfg_q, cfg_d;
   logic                            wr_strobe_q, wr_strobe_d;
   logic                            start_q, start_d;
   logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;

   logic                            w_ar_rise, w_wv_rise, w_commit;
   logic [7:0]                      w_clr;
   logic [DATA_WIDTH-1:0]           w_rd_sel;

   function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
      return 32'(a) < 32'(4 + NUM_CFG);
   endfunction

   // arm_q blocks a level left high across reset from looking like a new frame
   assign w_ar_rise = addr_ready & ~ar_q & arm_q;
   assign w_wv_rise = wr_valid & ~wv_q;
   assign arm_d     = arm_q | ~addr_ready;

   always_comb begin
      w_rd_sel = '0;
      if (addr == C_A_ID)      w_rd_sel = ID_VALUE;
      if (addr == C_A_CTRL)    w_rd_sel = ctrl_q;
      if (addr == C_A_STATUS)  w_rd_sel = {{(DATA_WIDTH-16){1'b0}}, bad_cnt_q, sticky_q};
      if (addr == C_A_SCRATCH) w_rd_sel = scratch_q;
      for (int k = 0; k < NUM_CFG; k++) begin
         if (addr == ADDR_WIDTH'(4 + k)) w_rd_sel = cfg_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      rd_data_d   = rd_data_q;
      bad_cnt_d   = bad_cnt_q;
      ctrl_d      = ctrl_q;
      scratch_d   = scratch_q;
      cfg_d       = cfg_q;
      wr_addr_d   = wr_addr_q;
      w_clr       = '0;
      w_commit    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_ar_rise) begin
               addr_d    = addr;
               rw_d      = rw;
               rd_data_d = w_rd_sel;
               if (!is_mapped(addr) && bad_cnt_q != 8'hFF) bad_cnt_d = bad_cnt_q + 8'd1;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (!addr_ready)    state_d = S_IDLE;
            else if (w_wv_rise) state_d = S_DATA;
         end
         S_DATA: begin
            w_commit = !rw_q && is_mapped(addr_q);
            state_d  = S_DONE;
         end
         default: begin
            if (!addr_ready) state_d = S_IDLE;
         end
      endcase

      if (w_commit) begin
         wr_addr_d = addr_q;
         if (addr_q == C_A_CTRL)    ctrl_d    = {wr_data[DATA_WIDTH-1:2], 1'b0, wr_data[0]};
         if (addr_q == C_A_STATUS)  w_clr     = wr_data[7:0];
         if (addr_q == C_A_SCRATCH) scratch_d = wr_data;
         for (int k = 0; k < NUM_CFG; k++) begin
            if (addr_q == ADDR_WIDTH'(4 + k)) cfg_d[k*DATA_WIDTH +: DATA_WIDTH] = wr_data;
         end
      end

      wr_strobe_d = w_commit;
      start_d     = w_commit && (addr_q == C_A_CTRL) && wr_data[1];
      // set wins over a simultaneous write-1-clear
      sticky_d    = (sticky_q & ~w_clr) | status_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ar_q        <= 1'b0;
         wv_q        <= 1'b0;
         arm_q       <= 1'b0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         rd_data_q   <= '0;
         ctrl_q      <= '0;
         scratch_q   <= '0;
         sticky_q    <= '0;
         bad_cnt_q   <= '0;
         cfg_q       <= '0;
         wr_strobe_q <= 1'b0;
         start_q     <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         ar_q        <= addr_ready;
         wv_q        <= wr_valid;
         arm_q       <= arm_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         rd_data_q   <= rd_data_d;
         ctrl_q      <= ctrl_d;
         scratch_q   <= scratch_d;
         sticky_q    <= sticky_d;
         bad_cnt_q   <= bad_cnt_d;
         cfg_q       <= cfg_d;
         wr_strobe_q <= wr_strobe_d;
         start_q     <= start_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   assign rd_data        = rd_data_q;
   assign ctrl_enable    = ctrl_q[0];
   assign start_pulse    = start_q;
   assign wr_strobe      = wr_strobe_q;
   assign wr_addr        = wr_addr_q;
   assign cfg_flat       = cfg_q;
   assign bad_addr_count = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_bank : directed frames against a register-map model of spi_reg_bank
// Revision        : 1.0
// ============================================================================
module tb_spi_reg_bank;

   logic         clk;
   logic         rst;
   logic [6:0]   addr;
   logic         addr_ready;
   logic         rw;
   logic [23:0]  wr_data;
   logic         wr_valid;
   logic [23:0]  rd_data;
   logic [7:0]   status_set;
   logic         ctrl_enable;
   logic         start_pulse;
   logic         wr_strobe;
   logic [6:0]   wr_addr;
   logic [287:0] cfg_flat;
   logic [7:0]   bad_addr_count;

   spi_reg_bank dut (
      .clk(clk), .rst(rst), .addr(addr), .addr_ready(addr_ready), .rw(rw),
      .wr_data(wr_data), .wr_valid(wr_valid), .rd_data(rd_data),
      .status_set(status_set), .ctrl_enable(ctrl_enable), .start_pulse(start_pulse),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .cfg_flat(cfg_flat),
      .bad_addr_count(bad_addr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // register-map model
   logic [23:0]  m_ctrl, m_scratch;
   logic [287:0] m_cfg_flat;
   logic [7:0]   m_sticky, m_bad, m_clr;

   // expected outputs after the next rising edge
   logic [23:0]  exp_rd_data;
   logic         exp_ctrl_en, exp_start, exp_wr_strobe;
   logic [6:0]   exp_wr_addr;
   logic [287:0] exp_cfg_flat;
   logic [7:0]   exp_bad;

   always @(posedge clk) begin
      if (rst) m_sticky <= 8'h00;
      else     m_sticky <= (m_sticky & ~m_clr) | status_set;
   end

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("rd_data", 288'(rd_data), 288'(exp_rd_data));
         chk("ctrl_enable", 288'(ctrl_enable), 288'(exp_ctrl_en));
         chk("start_pulse", 288'(start_pulse), 288'(exp_start));
         chk("wr_strobe", 288'(wr_strobe), 288'(exp_wr_strobe));
         chk("wr_addr", 288'(wr_addr), 288'(exp_wr_addr));
         chk("cfg_flat", cfg_flat, exp_cfg_flat);
         chk("bad_addr_count", 288'(bad_addr_count), 288'(exp_bad));
      end
   end

   function automatic logic [23:0] model_read(input logic [6:0] a);
      int ia = int'(a);
      if (ia == 0) return 24'h564E41;
      if (ia == 1) return m_ctrl;
      if (ia == 2) return {8'h00, m_bad, m_sticky};
      if (ia == 3) return m_scratch;
      if (ia >= 4 && ia < 16) return m_cfg_flat[(ia-4)*24 +: 24];
      return 24'h000000;
   endfunction

   task automatic model_reset();
      m_ctrl = '0; m_scratch = '0; m_cfg_flat = '0; m_bad = '0; m_clr = '0;
      exp_rd_data = '0; exp_ctrl_en = 1'b0; exp_start = 1'b0; exp_wr_strobe = 1'b0;
      exp_wr_addr = '0; exp_cfg_flat = '0; exp_bad = '0;
   endtask

   // One SPI frame; abort drops addr_ready before wr_valid, rst_mid resets in DATA.
   task automatic frame(input logic [6:0] a, input logic r, input logic [23:0] d,
                        input logic [7:0] set_c, input bit abort, input bit rst_mid);
      int ia = int'(a);
      @(negedge clk);
      addr = a; rw = r; addr_ready = 1'b1;
      exp_rd_data = model_read(a);
      if (ia >= 16 && m_bad != 8'hFF) m_bad = m_bad + 8'd1;
      exp_bad = m_bad;
      @(negedge clk);
      if (abort) begin
         addr_ready = 1'b0;
         @(negedge clk);
         return;
      end
      wr_valid = 1'b1; wr_data = d;
      @(negedge clk);
      if (rst_mid) begin
         rst = 1'b1;
         model_reset();
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      status_set = set_c;
      if (!r && ia < 16) begin
         exp_wr_strobe = 1'b1;
         exp_wr_addr   = a;
         if (ia == 1) begin
            m_ctrl      = d & ~24'h000002;
            exp_start   = d[1];
            exp_ctrl_en = d[0];
         end else if (ia == 2) begin
            m_clr = d[7:0];
         end else if (ia == 3) begin
            m_scratch = d;
         end else if (ia >= 4) begin
            m_cfg_flat[(ia-4)*24 +: 24] = d;
         end
         exp_cfg_flat = m_cfg_flat;
      end
      @(negedge clk);
      status_set = 8'h00; m_clr = 8'h00;
      exp_wr_strobe = 1'b0; exp_start = 1'b0;
      addr_ready = 1'b0; wr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = '0; addr_ready = 1'b0; rw = 1'b0; wr_data = '0;
      wr_valid = 1'b0; status_set = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rd_data", 288'(rd_data), 288'h0);
      chk("reset_bad_count", 288'(bad_addr_count), 288'h0);

      frame(7'h00, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("read_id", 288'(rd_data), 288'h564E41);

      frame(7'h04, 1'b0, 24'hABCDEF, 8'h00, 1'b0, 1'b0);
      chk("cfg0_flat", 288'(cfg_flat[23:0]), 288'hABCDEF);
      chk("cfg0_wr_addr", 288'(wr_addr), 288'h04);
      frame(7'h04, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("read_cfg0", 288'(rd_data), 288'hABCDEF);
      frame(7'h0F, 1'b0, 24'h13579B, 8'h00, 1'b0, 1'b0);
      chk("cfg11_flat", 288'(cfg_flat[287:264]), 288'h13579B);

      frame(7'h01, 1'b0, 24'h000003, 8'h00, 1'b0, 1'b0);
      chk("ctrl_enable", 288'(ctrl_enable), 288'h1);
      frame(7'h01, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("read_ctrl", 288'(rd_data), 288'h000001);

      @(negedge clk); status_set = 8'h05;
      @(negedge clk); status_set = 8'h00;
      frame(7'h02, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("status_set", 288'(rd_data), 288'h000005);
      frame(7'h02, 1'b0, 24'h000001, 8'h01, 1'b0, 1'b0);
      frame(7'h02, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("status_set_wins", 288'(rd_data), 288'h000005);
      frame(7'h02, 1'b0, 24'h000001, 8'h00, 1'b0, 1'b0);
      frame(7'h02, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("status_w1c", 288'(rd_data), 288'h000004);

      frame(7'h03, 1'b0, 24'h123456, 8'h00, 1'b0, 1'b0);
      frame(7'h03, 1'b0, 24'h654321, 8'h00, 1'b1, 1'b0);
      frame(7'h03, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("abort_scratch", 288'(rd_data), 288'h123456);

      frame(7'h7F, 1'b0, 24'hFFFFFF, 8'h00, 1'b0, 1'b0);
      chk("bad_count_1", 288'(bad_addr_count), 288'h1);
      chk("bad_wr_addr", 288'(wr_addr), 288'h03);
      for (int i = 0; i < 300; i++) frame(7'h7F, 1'b0, 24'h111111, 8'h00, 1'b0, 1'b0);
      chk("bad_count_sat", 288'(bad_addr_count), 288'hFF);
      frame(7'h02, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("status_with_count", 288'(rd_data), 288'h00FF04);

      frame(7'h03, 1'b0, 24'hAAAAAA, 8'h00, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("level_after_reset", 288'(rd_data), 288'h0);
      addr_ready = 1'b0; wr_valid = 1'b0;
      frame(7'h03, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("scratch_after_reset", 288'(rd_data), 288'h0);
      frame(7'h05, 1'b0, 24'h0000A5, 8'h00, 1'b0, 1'b0);
      frame(7'h05, 1'b1, 24'h0, 8'h00, 1'b0, 1'b0);
      chk("frame_after_reset", 288'(rd_data), 288'h0000A5);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register bank directly downstream of the SPI slave: consumes its decoded address, R/W flag and received data word, commits writes into a small control/status register map, and returns the readback word on the slave's data_in input before the first data bit is shifted out. Sits between the MCU SPI link and the VNA DSP datapath, exporting configuration words, a control enable, a start pulse and sticky status flags.

## Interface
- ADDR_WIDTH, 7, address field width (matches SPI slave)
- DATA_WIDTH, 24, data word width (32-bit frame minus address minus R/W bit)
- NUM_CFG, 12, number of generic RW config registers, mapped at 0x04..0x04+NUM_CFG-1
- ID_VALUE, 24'h564E41, constant returned at address 0x00
- clk  in  1  system clock, same domain as the SPI slave
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  decoded register address
- addr_ready  in  1  level, high from address capture until end of frame
- rw  in  1  1 = read, 0 = write; valid while addr_ready high
- wr_data  in  DATA_WIDTH  received data word
- wr_valid  in  1  level, high from word capture until end of frame
- rd_data  out  DATA_WIDTH  readback word, drives SPI slave data_in
- status_set  in  8  per-bit set requests for sticky status, level
- ctrl_enable  out  1  CTRL[0]
- start_pulse  out  1  one-cycle pulse on write of CTRL with bit 1 set
- wr_strobe  out  1  one-cycle pulse on every committed write
- wr_addr  out  ADDR_WIDTH  address of the last committed write
- cfg_flat  out  NUM_CFG*DATA_WIDTH  config registers, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- bad_addr_count  out  8  saturating count of accesses to unmapped addresses

## Operation
- Register map: 0x00 ID (RO); 0x01 CTRL (RW, bit0 enable, bit1 self-clearing start, reads back 0; bits 23:2 RW storage); 0x02 STATUS (bits 7:0 sticky, W1C; bits 15:8 read bad_addr_count; rest 0); 0x03 SCRATCH (RW); 0x04..0x04+NUM_CFG-1 CFG (RW). Everything else unmapped: reads 0, writes dropped, bad_addr_count +1 (saturates at 255), once per frame.
- Rising edges of addr_ready and wr_valid detected with one-cycle delayed copies (levels from slave are held, not pulsed).
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: on addr_ready rise, latch addr and rw, load rd_data with selected register value, go ADDR.
  - ADDR: on wr_valid rise -> DATA; on addr_ready low (frame abort, ncs high) -> IDLE with no write.
  - DATA: one cycle; if rw=0 and address mapped, commit wr_data, pulse wr_strobe, update wr_addr; if rw=1 no register change. -> DONE.
  - DONE: wait for addr_ready low -> IDLE.
- rd_data is a snapshot: held constant from load until next addr_ready rise; register changes mid-frame are not reflected.
- STATUS: status_set bit sets sticky bit every cycle it is high; write-1 clears. Simultaneous set and clear on a bit: set wins. Reading STATUS does not clear it.
- start_pulse asserted with wr_strobe when committed CTRL write has bit 1 = 1; CTRL[1] storage stays 0.
- rst: all registers, sticky bits, counters and outputs to 0, FSM to IDLE, regardless of frame in progress; edge detectors reset to 0 so a level-high addr_ready after reset is ignored until it drops and rises again.

## Timing
- Reset values: rd_data 0, ctrl_enable 0, start_pulse 0, wr_strobe 0, wr_addr 0, cfg_flat 0, bad_addr_count 0, STATUS 0.
- addr_ready rise sampled at cycle t -> rd_data valid at t+1 (slave needs it before next SCK falling edge; clk ≥ 4x SCK guarantees this).
- wr_valid rise sampled at cycle t -> FSM in DATA at t+1, register, wr_strobe, start_pulse, wr_addr updated/asserted at t+2; ctrl_enable/cfg_flat change at t+2.
- Back-to-back frames: addr_ready and wr_valid drop together; DONE -> IDLE one cycle later, next addr_ready rise accepted from IDLE only.
- bad_addr_count increments at the cycle leaving IDLE for ADDR.

## Test plan
- Reset, then read 0x00 -> rd_data = 24'h564E41 one cycle after addr_ready rise; all outputs 0 before.
- Write 0x04 = 24'hABCDEF -> wr_strobe one cycle, wr_addr = 0x04, cfg_flat[23:0] = 24'hABCDEF; subsequent read of 0x04 returns 24'hABCDEF.
- Write CTRL = 24'h000003 -> ctrl_enable = 1, start_pulse high exactly one cycle; read CTRL returns 24'h000001.
- status_set = 8'h05 for one cycle; read STATUS -> 24'h000005; write STATUS = 24'h000001 with status_set[0] high same cycle -> bit0 stays 1, bit2 remains 1; repeat with status_set low -> STATUS = 24'h000004.
- Write to 0x7F -> no wr_strobe, registers unchanged, bad_addr_count = 1; 300 such frames -> 255.
- Frame aborted (addr_ready falls before wr_valid) during write to 0x03 -> SCRATCH unchanged, no wr_strobe; rst asserted mid-frame -> all state 0, next frame decoded normally.
